matrix_alu_seq: RTL and testbench

Sequencer and datapath for matrix arithmetic on operands held in matrix_mem. It drives the memory's ALU read ports A/B, computes into an internal 25-word result buffer, then allocates one new result matrix and streams it through the ALU write port. Buffering the whole result means allocation never disturbs operands while they are still being read, including when the result spec equals an operand spec. The control UI sits upstream, issuing start/op; matrix_mem sits downstream.

---
 rtl/matrix_pkg.sv | 45 ++++
 rtl/matrix_idx_walker.sv | 68 ++++++
 rtl/matrix_alu_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the matrix ALU sequencer: op/error encodings,
// FSM states and result-buffer geometry.
package matrix_pkg;

    localparam int MAX_DIM   = 5;
    localparam int BUF_DEPTH = 25;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_SCALAR = 2'd1,
        OP_TRANS  = 2'd2,
        OP_MATMUL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_ARG  = 2'd1,
        ERR_MISMATCH = 2'd2
    } err_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        COMPUTE,
        ALLOC,
        WRITE,
        DONE
    } state_e;

    function automatic logic [4:0] buf_idx(
        input logic [2:0] r,
        input logic [2:0] c
    );
        return 5'(r) * 5'(MAX_DIM) + 5'(c);
    endfunction

    function automatic logic dim_ok(input logic [2:0] d);
        return (d >= 3'd1) && (d <= 3'(MAX_DIM));
    endfunction

    function automatic logic id_ok(input logic [1:0] i);
        return (i == 2'd1) || (i == 2'd2);
    endfunction

endpackage

// File: rtl/matrix_idx_walker.sv
// Nested row/col/k counter, k innermost, row-major over (row,col).
// Set k_max_i to 1 for a plain 2-level row/col walk.
module matrix_idx_walker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic [2:0] r_max_i,
    input  logic [2:0] c_max_i,
    input  logic [2:0] k_max_i,
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic [2:0] k_o,
    output logic       last_k_o,
    output logic       last_o
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [2:0] k_q, k_d;
    logic       last_k, last_c, last_r;

    assign last_k = (k_q == k_max_i - 3'd1);
    assign last_c = (col_q == c_max_i - 3'd1);
    assign last_r = (row_q == r_max_i - 3'd1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        k_d   = k_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
            k_d   = '0;
        end else if (adv_i) begin
            if (!last_k) begin
                k_d = k_q + 3'd1;
            end else begin
                k_d = '0;
                if (!last_c) begin
                    col_d = col_q + 3'd1;
                end else begin
                    col_d = '0;
                    row_d = last_r ? 3'd0 : row_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            k_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            k_q   <= k_d;
        end
    end

    assign row_o    = row_q;
    assign col_o    = col_q;
    assign k_o      = k_q;
    assign last_k_o = last_k;
    assign last_o   = last_k && last_c && last_r;

endmodule

// File: rtl/matrix_alu_seq.sv
// Matrix ALU sequencer: check, compute into buffer, alloc, write back.
// MATRIX_ALU_SAT_EN: saturate overflowing results to all-ones.
module matrix_alu_seq
    import matrix_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = 35
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [2:0]    a_m,
    input  logic [2:0]    a_n,
    input  logic [1:0]    a_id,
    input  logic [2:0]    b_m,
    input  logic [2:0]    b_n,
    input  logic [1:0]    b_id,
    input  logic [DW-1:0] scalar,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [2:0]    res_m,
    output logic [2:0]    res_n,
    output logic [2:0]    alu_a_m,
    output logic [2:0]    alu_a_n,
    output logic [2:0]    alu_a_row,
    output logic [2:0]    alu_a_col,
    output logic [1:0]    alu_a_id,
    input  logic [DW-1:0] alu_a_data,
    output logic [2:0]    alu_b_m,
    output logic [2:0]    alu_b_n,
    output logic [2:0]    alu_b_row,
    output logic [2:0]    alu_b_col,
    output logic [1:0]    alu_b_id,
    input  logic [DW-1:0] alu_b_data,
    output logic [2:0]    alu_res_m,
    output logic [2:0]    alu_res_n,
    output logic [2:0]    alu_res_row,
    output logic [2:0]    alu_res_col,
    output logic          alu_res_dim_we,
    output logic [DW-1:0] alu_res_data,
    output logic          alu_res_we
);

    state_e state_q, state_d;
    op_e    op_q;

    logic [2:0]       am_q, an_q, bm_q, bn_q;
    logic [1:0]       aid_q, bid_q;
    logic [DW-1:0]    scal_q;
    logic [2:0]       rm_q, rn_q, res_m_q, res_n_q;
    logic [2:0]       rm_c, rn_c;
    logic [1:0]       err_code_q, chk_code;
    logic             err_q;
    logic             use_b, bad_arg, mismatch;
    logic [ACC_W-1:0] acc_q, acc_sum, val_full;
    logic [DW-1:0]    val;
    logic             in_comp, in_wr, buf_we;
    logic [2:0]       w_row, w_col, w_k, k_max;
    logic             w_last_k, w_last;
    logic [DW-1:0]    rbuf_q [BUF_DEPTH];

    assign in_comp = (state_q == COMPUTE);
    assign in_wr   = (state_q == WRITE);

    assign use_b   = (op_q == OP_ADD) || (op_q == OP_MATMUL);
    assign bad_arg = !dim_ok(am_q) || !dim_ok(an_q) || !id_ok(aid_q)
                  || (use_b && (!dim_ok(bm_q) || !dim_ok(bn_q)
                                || !id_ok(bid_q)));
    assign mismatch = ((op_q == OP_ADD)
                       && ((am_q != bm_q) || (an_q != bn_q)))
                   || ((op_q == OP_MATMUL) && (an_q != bm_q));

    always_comb begin
        chk_code = ERR_NONE;
        if (bad_arg)       chk_code = ERR_BAD_ARG;
        else if (mismatch) chk_code = ERR_MISMATCH;
    end

    always_comb begin
        rm_c = am_q;
        rn_c = an_q;
        case (op_q)
            OP_TRANS:  begin rm_c = an_q; rn_c = am_q; end
            OP_MATMUL: rn_c = bn_q;
            default:   ;
        endcase
    end

    assign k_max = (in_comp && op_q == OP_MATMUL) ? an_q : 3'd1;

    matrix_idx_walker u_walk (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    ((state_q == CHECK) || (state_q == ALLOC)),
        .adv_i    (in_comp || in_wr),
        .r_max_i  (rm_q),
        .c_max_i  (rn_q),
        .k_max_i  (k_max),
        .row_o    (w_row),
        .col_o    (w_col),
        .k_o      (w_k),
        .last_k_o (w_last_k),
        .last_o   (w_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = (chk_code != ERR_NONE) ? DONE : COMPUTE;
            COMPUTE: if (w_last) state_d = ALLOC;
            ALLOC:   state_d = WRITE;
            WRITE:   if (w_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_ADD;
            am_q       <= '0;
            an_q       <= '0;
            bm_q       <= '0;
            bn_q       <= '0;
            aid_q      <= '0;
            bid_q      <= '0;
            scal_q     <= '0;
            rm_q       <= '0;
            rn_q       <= '0;
            res_m_q    <= '0;
            res_n_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            acc_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                op_q       <= op_e'(op);
                am_q       <= a_m;
                an_q       <= a_n;
                bm_q       <= b_m;
                bn_q       <= b_n;
                aid_q      <= a_id;
                bid_q      <= b_id;
                scal_q     <= scalar;
                err_q      <= 1'b0;
                err_code_q <= '0;
            end
            if (state_q == CHECK) begin
                err_q      <= (chk_code != ERR_NONE);
                err_code_q <= chk_code;
                rm_q       <= rm_c;
                rn_q       <= rn_c;
            end
            if (in_comp && op_q == OP_MATMUL) acc_q <= acc_sum;
            if (in_wr && w_last) begin
                res_m_q <= rm_q;
                res_n_q <= rn_q;
            end
        end
    end

    // k==0 restarts the dot product without a separate clear cycle
    assign acc_sum = ((w_k == 3'd0) ? '0 : acc_q)
                   + ACC_W'(alu_a_data) * ACC_W'(alu_b_data);

    always_comb begin
        val_full = '0;
        case (op_q)
            OP_ADD:    val_full = ACC_W'(alu_a_data) + ACC_W'(alu_b_data);
            OP_SCALAR: val_full = ACC_W'(alu_a_data) * ACC_W'(scal_q);
            OP_TRANS:  val_full = ACC_W'(alu_a_data);
            OP_MATMUL: val_full = acc_sum;
            default:   val_full = '0;
        endcase
    end

`ifdef MATRIX_ALU_SAT_EN
    assign val = (|val_full[ACC_W-1:DW]) ? '1 : val_full[DW-1:0];
`else
    assign val = val_full[DW-1:0];
`endif

    assign buf_we = in_comp && ((op_q != OP_MATMUL) || w_last_k);

    always_ff @(posedge clk) begin
        if (buf_we) rbuf_q[buf_idx(w_row, w_col)] <= val;
    end

    always_comb begin
        alu_a_m   = '0;
        alu_a_n   = '0;
        alu_a_id  = '0;
        alu_a_row = '0;
        alu_a_col = '0;
        alu_b_m   = '0;
        alu_b_n   = '0;
        alu_b_id  = '0;
        alu_b_row = '0;
        alu_b_col = '0;
        if (in_comp) begin
            alu_a_m   = am_q;
            alu_a_n   = an_q;
            alu_a_id  = aid_q;
            alu_a_row = w_row;
            alu_a_col = w_col;
            if (use_b) begin
                alu_b_m   = bm_q;
                alu_b_n   = bn_q;
                alu_b_id  = bid_q;
                alu_b_row = w_row;
                alu_b_col = w_col;
            end
            case (op_q)
                OP_TRANS: begin
                    alu_a_row = w_col;
                    alu_a_col = w_row;
                end
                OP_MATMUL: begin
                    alu_a_col = w_k;
                    alu_b_row = w_k;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_res_m      = '0;
        alu_res_n      = '0;
        alu_res_row    = '0;
        alu_res_col    = '0;
        alu_res_data   = '0;
        alu_res_dim_we = 1'b0;
        alu_res_we     = 1'b0;
        unique case (1'b1)
            (state_q == ALLOC): begin
                alu_res_m      = rm_q;
                alu_res_n      = rn_q;
                alu_res_dim_we = 1'b1;
            end
            in_wr: begin
                alu_res_m    = rm_q;
                alu_res_n    = rn_q;
                alu_res_row  = w_row;
                alu_res_col  = w_col;
                alu_res_data = rbuf_q[buf_idx(w_row, w_col)];
                alu_res_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE) && !err_q;
    assign err      = (state_q == DONE) && err_q;
    assign err_code = err_code_q;
    assign res_m    = res_m_q;
    assign res_n    = res_n_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed bench for matrix_alu_seq with a matrix_mem model
// and an expected-write scoreboard.
module tb_matrix_alu_seq;
    import matrix_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [2:0]    a_m = '0, a_n = '0, b_m = '0, b_n = '0;
    logic [1:0]    a_id = '0, b_id = '0;
    logic [DW-1:0] scalar = '0;

    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [2:0]    res_m, res_n;
    logic [2:0]    alu_a_m, alu_a_n, alu_a_row, alu_a_col;
    logic [1:0]    alu_a_id;
    logic [DW-1:0] alu_a_data;
    logic [2:0]    alu_b_m, alu_b_n, alu_b_row, alu_b_col;
    logic [1:0]    alu_b_id;
    logic [DW-1:0] alu_b_data;
    logic [2:0]    alu_res_m, alu_res_n, alu_res_row, alu_res_col;
    logic          alu_res_dim_we, alu_res_we;
    logic [DW-1:0] alu_res_data;

    logic [DW-1:0] m1 [25];
    logic [DW-1:0] m2 [25];
    logic [DW-1:0] wr [25];
    logic          alloc_seen = 1'b0;
    logic [21:0]   exq [$];
    logic [68:0]   all_outs;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // slot 1 reads back garbage once a result has been allocated
    assign alu_a_data = (alu_a_id == 2'd2)
        ? m2[buf_idx(alu_a_row, alu_a_col)]
        : (alloc_seen ? 16'hDEAD : m1[buf_idx(alu_a_row, alu_a_col)]);
    assign alu_b_data = (alu_b_id == 2'd2)
        ? m2[buf_idx(alu_b_row, alu_b_col)]
        : (alloc_seen ? 16'hDEAD : m1[buf_idx(alu_b_row, alu_b_col)]);

    assign all_outs = {busy, done, err, err_code, res_m, res_n,
                       alu_a_m, alu_a_n, alu_a_row, alu_a_col, alu_a_id,
                       alu_b_m, alu_b_n, alu_b_row, alu_b_col, alu_b_id,
                       alu_res_m, alu_res_n, alu_res_row, alu_res_col,
                       alu_res_dim_we, alu_res_data, alu_res_we};

    matrix_alu_seq #(.DW(16), .ACC_W(35)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .op             (op),
        .a_m            (a_m),
        .a_n            (a_n),
        .a_id           (a_id),
        .b_m            (b_m),
        .b_n            (b_n),
        .b_id           (b_id),
        .scalar         (scalar),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code),
        .res_m          (res_m),
        .res_n          (res_n),
        .alu_a_m        (alu_a_m),
        .alu_a_n        (alu_a_n),
        .alu_a_row      (alu_a_row),
        .alu_a_col      (alu_a_col),
        .alu_a_id       (alu_a_id),
        .alu_a_data     (alu_a_data),
        .alu_b_m        (alu_b_m),
        .alu_b_n        (alu_b_n),
        .alu_b_row      (alu_b_row),
        .alu_b_col      (alu_b_col),
        .alu_b_id       (alu_b_id),
        .alu_b_data     (alu_b_data),
        .alu_res_m      (alu_res_m),
        .alu_res_n      (alu_res_n),
        .alu_res_row    (alu_res_row),
        .alu_res_col    (alu_res_col),
        .alu_res_dim_we (alu_res_dim_we),
        .alu_res_data   (alu_res_data),
        .alu_res_we     (alu_res_we)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fit(input longint v);
`ifdef MATRIX_ALU_SAT_EN
        return (v > 65535) ? 16'hFFFF : v[15:0];
`else
        return v[15:0];
`endif
    endfunction

    function automatic longint mrd(input logic [1:0] id, input int r,
                                   input int c);
        return (id == 2'd2) ? longint'(m2[r*5+c]) : longint'(m1[r*5+c]);
    endfunction

    task automatic clr_mem();
        for (int i = 0; i < 25; i++) begin
            m1[i] = '0;
            m2[i] = '0;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 25; i++) begin
            m1[i] = 16'($urandom_range(0, 65535));
            m2[i] = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [2:0] am, input logic [2:0] an,
                       input logic [1:0] aid,
                       input logic [2:0] bm, input logic [2:0] bn,
                       input logic [1:0] bid,
                       input logic [15:0] sc, input logic [1:0] xerr,
                       input int xcyc);
        int cyc, nwr, nal, nexp;
        bit fin, prev;
        logic [2:0] rm, rn;
        longint v;
        logic [21:0] e;
        exq.delete();
        for (int i = 0; i < 25; i++) wr[i] = '0;
        rm = (o == 2'd2) ? an : am;
        rn = (o == 2'd2) ? am : ((o == 2'd3) ? bn : an);
        if (xerr == 2'd0) begin
            for (int r = 0; r < int'(rm); r++) begin
                for (int c = 0; c < int'(rn); c++) begin
                    v = 0;
                    case (o)
                        2'd0: v = mrd(aid, r, c) + mrd(bid, r, c);
                        2'd1: v = mrd(aid, r, c) * longint'(sc);
                        2'd2: v = mrd(aid, c, r);
                        default:
                            for (int k = 0; k < int'(an); k++)
                                v += mrd(aid, r, k) * mrd(bid, k, c);
                    endcase
                    exq.push_back({3'(r), 3'(c), fit(v)});
                end
            end
        end
        nexp = exq.size();
        @(negedge clk);
        op = o; a_m = am; a_n = an; a_id = aid;
        b_m = bm; b_n = bn; b_id = bid; scalar = sc;
        start = 1'b1;
        alloc_seen = 1'b0;
        cyc = 0; nwr = 0; nal = 0; fin = 0; prev = 0;
        while (!fin && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                op = ~o; a_m = 3'd7; a_n = 3'd7; b_m = 3'd7; b_n = 3'd7;
                a_id = 2'd3; b_id = 2'd3; scalar = ~sc;
                chk({tag, "_busy"}, busy, 1'b1);
            end
            if (cyc == 3) start = 1'b0;
            if (alloc_seen == 1'b0 && alu_res_dim_we) alloc_seen = 1'b1;
            if (alu_res_dim_we) begin
                nal++;
                chk({tag, "_alloc"}, {alu_res_m, alu_res_n}, {rm, rn});
            end
            if (alu_res_we) begin
                if (nwr == 0) chk({tag, "_wr_after_alloc"}, prev, 1'b1);
                nwr++;
                if (exq.size() > 0) begin
                    e = exq.pop_front();
                    chk({tag, "_wr"},
                        {alu_res_row, alu_res_col, alu_res_data}, e);
                end
                wr[buf_idx(alu_res_row, alu_res_col)] = alu_res_data;
            end
            prev = alu_res_dim_we;
            fin = done || err;
            if (cyc == 2 && !fin) start = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_finished"}, fin, 1'b1);
        chk({tag, "_cycles"}, cyc, xcyc);
        chk({tag, "_status"}, {done, err, err_code},
            {(xerr == 2'd0), (xerr != 2'd0), xerr});
        chk({tag, "_nwrites"}, nwr, nexp);
        chk({tag, "_nallocs"}, nal, (xerr == 2'd0) ? 1 : 0);
        if (xerr == 2'd0) chk({tag, "_res_dims"}, {res_m, res_n}, {rm, rn});
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done, err}, 3'b000);
    endtask

    initial begin
        int nstb;
        clr_mem();
        #3;
        chk("reset_outs", all_outs, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", all_outs, 128'd0);

        clr_mem();
        m1[0] = 16'd1;  m1[1] = 16'd2;  m1[5] = 16'd3;  m1[6] = 16'd4;
        m2[0] = 16'd10; m2[1] = 16'd20; m2[5] = 16'd30; m2[6] = 16'd40;
        run("add2x2", 2'd0, 3'd2, 3'd2, 2'd1, 3'd2, 3'd2, 2'd2,
            16'd0, 2'd0, 11);
        chk("add2x2_vals", {wr[0], wr[1], wr[5], wr[6]},
            {16'd11, 16'd22, 16'd33, 16'd44});

        clr_mem();
        m1[0] = 16'd1; m1[1] = 16'd2; m1[2] = 16'd3;
        m1[5] = 16'd4; m1[6] = 16'd5; m1[7] = 16'd6;
        run("trans2x3", 2'd2, 3'd2, 3'd3, 2'd1, 3'd0, 3'd0, 2'd0,
            16'd0, 2'd0, 15);
        chk("trans2x3_vals",
            {wr[0], wr[1], wr[5], wr[6], wr[10], wr[11]},
            {16'd1, 16'd4, 16'd2, 16'd5, 16'd3, 16'd6});

        m2[0] = 16'd7;  m2[1] = 16'd8;
        m2[5] = 16'd9;  m2[6] = 16'd10;
        m2[10] = 16'd11; m2[11] = 16'd12;
        run("mm2x3x2", 2'd3, 3'd2, 3'd3, 2'd1, 3'd3, 3'd2, 2'd2,
            16'd0, 2'd0, 19);
        chk("mm2x3x2_vals", {wr[0], wr[1], wr[5], wr[6]},
            {16'd58, 16'd64, 16'd139, 16'd154});

        run("mm_mismatch", 2'd3, 3'd2, 3'd3, 2'd1, 3'd2, 3'd2, 2'd2,
            16'd0, 2'd2, 2);
        run("add_am0", 2'd0, 3'd0, 3'd2, 2'd1, 3'd2, 3'd2, 2'd2,
            16'd0, 2'd1, 2);
        run("scal_badid", 2'd1, 3'd2, 3'd2, 2'd3, 3'd0, 3'd0, 2'd0,
            16'd3, 2'd1, 2);

        clr_mem();
        m1[0] = 16'd300;
        run("scal1x1", 2'd1, 3'd1, 3'd1, 2'd1, 3'd0, 3'd0, 2'd0,
            16'd300, 2'd0, 5);
`ifdef MATRIX_ALU_SAT_EN
        chk("scal1x1_val", wr[0], 16'd65535);
`else
        chk("scal1x1_val", wr[0], 16'd24464);
`endif

        fill_rand();
        run("add_same_id", 2'd0, 3'd3, 3'd3, 2'd1, 3'd3, 3'd3, 2'd1,
            16'd0, 2'd0, 21);

        fill_rand();
        run("mm4x5x3", 2'd3, 3'd4, 3'd5, 2'd1, 3'd5, 3'd3, 2'd2,
            16'd0, 2'd0, 75);

        fill_rand();
        run("scal5x5", 2'd1, 3'd5, 3'd5, 2'd2, 3'd0, 3'd0, 2'd0,
            16'd2, 2'd0, 53);

        fill_rand();
        @(negedge clk);
        op = 2'd3; a_m = 3'd5; a_n = 3'd5; a_id = 2'd1;
        b_m = 3'd5; b_n = 3'd5; b_id = 2'd2;
        start = 1'b1;
        alloc_seen = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nstb = 0;
        repeat (6) begin
            @(negedge clk);
            if (alu_res_we || alu_res_dim_we) nstb++;
        end
        chk("rst_mid_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_async_zero", all_outs, 128'd0);
        @(negedge clk);
        chk("rst_mid_held_zero", all_outs, 128'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (alu_res_we || alu_res_dim_we) nstb++;
        end
        chk("rst_mid_no_strobe", nstb, 0);
        chk("rst_mid_idle", busy, 1'b0);

        clr_mem();
        m1[0] = 16'd5; m1[1] = 16'd6; m1[5] = 16'd7; m1[6] = 16'd8;
        m2[0] = 16'd1; m2[1] = 16'd1; m2[5] = 16'd1; m2[6] = 16'd1;
        run("add_after_rst", 2'd0, 3'd2, 3'd2, 2'd1, 3'd2, 3'd2, 2'd2,
            16'd0, 2'd0, 11);
        chk("add_after_rst_vals", {wr[0], wr[1], wr[5], wr[6]},
            {16'd6, 16'd7, 16'd8, 16'd9});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
